// File: rtl/xor_frame_acc_pkg.sv
// Shared types and helpers for the XOR frame accumulator.
package xor_frame_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned CNT_W_DEF = 8;

  // Saturation value of a CNT_W-bit beat counter.
  function automatic longint unsigned cnt_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/xor_frame_acc_core.sv
// Accumulator registers: running column XOR, saturating beat count, overflow flag.
module xor_frame_acc_core
  import xor_frame_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] col_upd_c,
  output logic [CNT_W-1:0] cnt_upd_c,
  output logic             ovf_upd_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [WIDTH-1:0] col_acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_acc;

  // Values after absorbing the current beat; the top snapshots them on the last beat.
  assign col_upd_c = col_acc ^ data;
  assign cnt_upd_c = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign ovf_upd_c = ovf_acc | (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_acc <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (clr) begin
      col_acc <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (en) begin
      col_acc <= col_upd_c;
      cnt     <= cnt_upd_c;
      ovf_acc <= ovf_upd_c;
    end
  end

endmodule

// File: rtl/xor_frame_acc.sv
// Frame-level XOR parity accumulator with valid/ready in and out.
// Optional parity check port set enabled by XOR_FRAME_ACC_CHECK_EN.
module xor_frame_acc
  import xor_frame_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_col_par,
  output logic             out_frame_par,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
`ifdef XOR_FRAME_ACC_CHECK_EN
  ,
  input  logic             in_exp_par,
  output logic             out_err
`endif
);

  state_e           state_q;
  state_e           state_d;
  logic             accept;
  logic             close;
  logic [WIDTH-1:0] col_upd_c;
  logic [CNT_W-1:0] cnt_upd_c;
  logic             ovf_upd_c;

  // Ready is a pure state decode, independent of out_ready.
  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;
  assign close    = accept && in_last;

  xor_frame_acc_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (accept),
    .clr       (close),
    .data      (in_data),
    .col_upd_c (col_upd_c),
    .cnt_upd_c (cnt_upd_c),
    .ovf_upd_c (ovf_upd_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACC: if (accept) state_d = in_last ? HOLD : ACC;
      HOLD:      if (out_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Result registers load on the closing beat; data persists after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_col_par   <= '0;
      out_frame_par <= 1'b0;
      out_count     <= '0;
      out_ovf       <= 1'b0;
`ifdef XOR_FRAME_ACC_CHECK_EN
      out_err       <= 1'b0;
`endif
    end else if (close) begin
      out_valid     <= 1'b1;
      out_col_par   <= col_upd_c;
      out_frame_par <= ^col_upd_c;
      out_count     <= cnt_upd_c;
      out_ovf       <= ovf_upd_c;
`ifdef XOR_FRAME_ACC_CHECK_EN
      out_err       <= (^col_upd_c) ^ in_exp_par;
`endif
    end else if ((state_q == HOLD) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_frame_acc.sv
// Self-checking bench: two instances (8-bit and 2-bit counters) on shared stimulus.
module tb_xor_frame_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_frame_par, a_ovf;
  logic [3:0] a_col;
  logic [7:0] a_count;
  logic       b_in_ready, b_out_valid, b_frame_par, b_ovf;
  logic [3:0] b_col;
  logic [1:0] b_count;
`ifdef XOR_FRAME_ACC_CHECK_EN
  logic       in_exp_par;
  logic       a_err, b_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] frame_q[$];

  always #5 clk = ~clk;

  xor_frame_acc #(.WIDTH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_col_par(a_col), .out_frame_par(a_frame_par),
    .out_count(a_count), .out_ovf(a_ovf)
`ifdef XOR_FRAME_ACC_CHECK_EN
    , .in_exp_par(in_exp_par), .out_err(a_err)
`endif
  );

  xor_frame_acc #(.WIDTH(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_col_par(b_col), .out_frame_par(b_frame_par),
    .out_count(b_count), .out_ovf(b_ovf)
`ifdef XOR_FRAME_ACC_CHECK_EN
    , .in_exp_par(in_exp_par), .out_err(b_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_a_valid", a_out_valid, 0); chk("rst_a_col", a_col, 0);
    chk("rst_a_fpar", a_frame_par, 0);  chk("rst_a_count", a_count, 0);
    chk("rst_a_ovf", a_ovf, 0);         chk("rst_a_ready", a_in_ready, 1);
    chk("rst_b_valid", b_out_valid, 0); chk("rst_b_count", b_count, 0);
    chk("rst_b_ovf", b_ovf, 0);         chk("rst_b_ready", b_in_ready, 1);
`ifdef XOR_FRAME_ACC_CHECK_EN
    chk("rst_a_err", a_err, 0);
`endif
  endtask

  // Sends frame_q as one frame and checks the result against the reference model.
  task automatic run_frame(input int bp, input logic exp_par, input bit gaps);
    int n = frame_q.size();
    logic [3:0] col = 4'h0;
    int ones = 0;
    int cnt_a, cnt_b;
    foreach (frame_q[i]) begin
      col ^= frame_q[i];
      ones += $countones(frame_q[i]);
    end
    cnt_a = (n > 255) ? 255 : n;
    cnt_b = (n > 3) ? 3 : n;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; in_last = 1'($urandom); in_data = 4'($urandom);
        @(posedge clk); @(negedge clk);
      end
      if (i == 0) chk("first_ready", a_in_ready, 1);
      in_valid = 1'b1; in_data = frame_q[i]; in_last = (i == n - 1);
`ifdef XOR_FRAME_ACC_CHECK_EN
      in_exp_par = (i == n - 1) ? exp_par : ~exp_par;
`endif
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("res_a_valid", a_out_valid, 1);   chk("res_b_valid", b_out_valid, 1);
    chk("res_a_ready", a_in_ready, 0);    chk("res_a_col", a_col, col);
    chk("res_b_col", b_col, col);         chk("res_a_fpar", a_frame_par, ones % 2);
    chk("res_a_count", a_count, cnt_a);   chk("res_b_count", b_count, cnt_b);
    chk("res_a_ovf", a_ovf, n > 255);     chk("res_b_ovf", b_ovf, n > 3);
`ifdef XOR_FRAME_ACC_CHECK_EN
    chk("res_a_err", a_err, (ones % 2) ^ exp_par);
`endif
    // Offered words during HOLD must be refused.
    in_valid = 1'b1; in_last = 1'b1; in_data = 4'($urandom);
    for (int c = 0; c < bp; c++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_a_valid", a_out_valid, 1); chk("hold_a_ready", a_in_ready, 0);
      chk("hold_a_col", a_col, col);       chk("hold_b_count", b_count, cnt_b);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("hs_a_valid", a_out_valid, 0); chk("hs_b_valid", b_out_valid, 0);
    chk("hs_a_ready", a_in_ready, 1);  chk("hs_a_col_kept", a_col, col);
    chk("hs_a_count_kept", a_count, cnt_a);
    frame_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; in_last = 1'b0; out_ready = 1'b0;
`ifdef XOR_FRAME_ACC_CHECK_EN
    in_exp_par = 1'b0;
`endif
    #2 chk_reset_outputs();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    // Two-beat frame.
    frame_q = '{4'b0001, 4'b0011};
    run_frame(0, 1'b1, 1'b0);
    // Single-beat frame with 5 cycles of backpressure.
    frame_q = '{4'b1111};
    run_frame(5, 1'b0, 1'b0);
    // Counter saturation on the 2-bit instance.
    frame_q = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    run_frame(1, 1'b1, 1'b0);

    // Reset mid-frame discards partial state.
    in_valid = 1'b1; in_data = 4'b1010; in_last = 1'b0;
    @(posedge clk); @(negedge clk);
    in_data = 4'b0110;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2 chk_reset_outputs();
    @(negedge clk); rst_n = 1'b1;
    frame_q = '{4'b0101};
    run_frame(0, 1'b0, 1'b0);

`ifdef XOR_FRAME_ACC_CHECK_EN
    frame_q = '{4'b0111};
    run_frame(0, 1'b0, 1'b0);
    frame_q = '{4'b0111};
    run_frame(0, 1'b1, 1'b0);
`endif

    // Reset while holding a result.
    frame_q = '{4'b0011, 4'b1100, 4'b0001};
    run_frame(0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 4'b1001; in_last = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("pre_rst_hold", a_out_valid, 1);
    rst_n = 1'b0;
    #2 chk_reset_outputs();
    @(negedge clk); rst_n = 1'b1;

    // Randomized frames against the model.
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) frame_q.push_back(4'($urandom));
      run_frame($urandom_range(0, 3), 1'($urandom), 1'b1);
    end

    // Long frame saturates the 8-bit counter.
    for (int i = 0; i < 260; i++) frame_q.push_back(4'($urandom));
    run_frame(2, 1'($urandom), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
